// File: rtl/eff_1_clip.sv
// ---------------------------------------------------------------------------
// eff_1_clip -- hard-clipping effect stage for the unsigned 8-bit sample
// stream between the UART byte receiver and the transmit/playback path.
//
// Each sample strobed in on data_valid is limited to [CLIP_LO, CLIP_HI] and
// registered; the result is held until the next accepted sample.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz (informational)
//   DATA_W    sample width, unsigned
//   CLIP_HI   upper clip level (0 .. 2^DATA_W-1)
//   CLIP_LO   lower clip level, must not exceed CLIP_HI
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   data_valid     single-cycle strobe qualifying receive_byte
//   receive_byte   input sample
//   clipping_byte  registered clipped sample, held between strobes
//   o_valid        one-cycle pulse: clipping_byte updated on this edge
//   o_clipped      last accepted sample was limited (high or low)
//   clip_count     16-bit saturating count of clipped samples
//                  (only when EFF_1_CLIP_COUNT_EN is defined)
//
// Optional feature macro: EFF_1_CLIP_COUNT_EN
// ---------------------------------------------------------------------------
module eff_1_clip #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DATA_W   = 8,
  parameter int CLIP_HI  = 200,
  parameter int CLIP_LO  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] receive_byte,
  output logic [DATA_W-1:0] clipping_byte,
  output logic              o_valid,
  output logic              o_clipped
`ifdef EFF_1_CLIP_COUNT_EN
  ,
  output logic [15:0]       clip_count
`endif
);

  localparam logic [DATA_W-1:0] HI_Q = DATA_W'(CLIP_HI);
  localparam logic [DATA_W-1:0] LO_Q = DATA_W'(CLIP_LO);

  // Elaboration-time sanity checks on the configuration.
  if (CLIP_LO > CLIP_HI) begin : g_bad_order
    $error("eff_1_clip: CLIP_LO must not exceed CLIP_HI");
  end
  if (CLIP_LO < 0 || CLIP_HI > (2 ** DATA_W) - 1) begin : g_bad_range
    $error("eff_1_clip: clip levels outside 0..2^DATA_W-1");
  end
  if (CLK_FREQ <= 0) begin : g_bad_clk
    $error("eff_1_clip: CLK_FREQ must be positive");
  end

  // Select the limited sample; returns {clipped_flag, sample}.
  function automatic logic [DATA_W:0] clip_sample(
    input logic [DATA_W-1:0] v,
    input logic              above_hi,
    input logic              below_lo
  );
    logic [DATA_W:0] r;
    r = {1'b0, v};
    if (above_hi)      r = {1'b1, HI_Q};
    else if (below_lo) r = {1'b1, LO_Q};
    return r;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // ---- Stage p0: compare against the clip levels ----
  logic              above_hi_p0;
  logic              below_lo_p0;
  logic [DATA_W-1:0] byte_p0;
  logic              clipped_p0;

  // A level sitting at the edge of the sample range can never be crossed,
  // so its comparator is tied off rather than built as a constant compare.
  if (CLIP_HI < (2 ** DATA_W) - 1) begin : g_hi_cmp
    assign above_hi_p0 = receive_byte > HI_Q;
  end else begin : g_hi_none
    assign above_hi_p0 = 1'b0;
  end

  if (CLIP_LO > 0) begin : g_lo_cmp
    assign below_lo_p0 = receive_byte < LO_Q;
  end else begin : g_lo_none
    assign below_lo_p0 = 1'b0;
  end

  always_comb begin
    {clipped_p0, byte_p0} = clip_sample(receive_byte, above_hi_p0, below_lo_p0);
  end

  // ---- Stage p1: output register ----
  logic [DATA_W-1:0] byte_p1;
  logic              clipped_p1;
  logic              vld_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_p1    <= '0;
      clipped_p1 <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= data_valid;
      if (data_valid) begin
        byte_p1    <= byte_p0;
        clipped_p1 <= clipped_p0;
      end
    end
  end

  assign clipping_byte = byte_p1;
  assign o_clipped     = clipped_p1;
  assign o_valid       = vld_p1;

`ifdef EFF_1_CLIP_COUNT_EN
  logic [15:0] cnt_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_p1 <= '0;
    end else if (data_valid && clipped_p0) begin
      cnt_p1 <= sat_inc16(cnt_p1);
    end
  end

  assign clip_count = cnt_p1;
`endif

endmodule

// File: tb/tb_eff_1_clip.sv
module tb_eff_1_clip;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv1, dv2;
  logic [7:0] rb1, rb2;
  logic [7:0] cb1, cb2;
  logic       ov1, ov2, oc1, oc2;
`ifdef EFF_1_CLIP_COUNT_EN
  logic [15:0] cnt1, cnt2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] q1[$];
  logic [8:0] q2[$];

  always #5 clk = ~clk;

  eff_1_clip #(.DATA_W(8), .CLIP_HI(200), .CLIP_LO(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .data_valid(dv1), .receive_byte(rb1),
    .clipping_byte(cb1), .o_valid(ov1), .o_clipped(oc1)
`ifdef EFF_1_CLIP_COUNT_EN
    , .clip_count(cnt1)
`endif
  );

  eff_1_clip #(.DATA_W(8), .CLIP_HI(200), .CLIP_LO(50)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .data_valid(dv2), .receive_byte(rb2),
    .clipping_byte(cb2), .o_valid(ov2), .o_clipped(oc2)
`ifdef EFF_1_CLIP_COUNT_EN
    , .clip_count(cnt2)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: pop expected {flag,byte} whenever a DUT reports a new output.
  always @(negedge clk) begin
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) chk("dut1_unexpected_valid", 1, 0);
      else begin
        logic [8:0] e;
        e = q1.pop_front();
        chk("dut1_byte", cb1, e[7:0]);
        chk("dut1_clipped", oc1, e[8]);
      end
    end
  end

  always @(negedge clk) begin
    if (ov2 === 1'b1) begin
      if (q2.size() == 0) chk("dut2_unexpected_valid", 1, 0);
      else begin
        logic [8:0] e;
        e = q2.pop_front();
        chk("dut2_byte", cb2, e[7:0]);
        chk("dut2_clipped", oc2, e[8]);
      end
    end
  end

  // One cycle of stimulus for dut1, set up on the falling edge.
  task automatic drv1(input logic r, input logic v, input logic [7:0] d,
                      input logic [7:0] exp_b, input logic exp_c);
    @(negedge clk);
    rst = r; dv1 = v; rb1 = d;
    if (v && !r) q1.push_back({exp_c, exp_b});
  endtask

  task automatic drv2(input logic v, input logic [7:0] d,
                      input logic [7:0] exp_b, input logic exp_c);
    @(negedge clk);
    dv2 = v; rb2 = d;
    if (v) q2.push_back({exp_c, exp_b});
  endtask

  task automatic idle1(input logic [7:0] d);
    drv1(1'b0, 1'b0, d, 8'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; dv1 = 1'b0; dv2 = 1'b0; rb1 = 8'd0; rb2 = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_byte", cb1, 0);
    chk("reset_valid", ov1, 0);
    chk("reset_clipped", oc1, 0);
`ifdef EFF_1_CLIP_COUNT_EN
    chk("reset_count", cnt1, 0);
`endif

    // In-range samples pass unchanged, including the boundary 200.
    drv1(0, 1, 8'd0,   8'd0,   0);
    drv1(0, 1, 8'd50,  8'd50,  0);
    drv1(0, 1, 8'd100, 8'd100, 0);
    drv1(0, 1, 8'd150, 8'd150, 0);
    drv1(0, 1, 8'd199, 8'd199, 0);
    drv1(0, 1, 8'd200, 8'd200, 0);
    idle1(8'd0);

    // Over-range samples, strobed with gaps so o_valid pulses can be seen.
    drv1(0, 1, 8'd201, 8'd200, 1); idle1(8'd0);
    drv1(0, 1, 8'd220, 8'd200, 1); idle1(8'd0);
    drv1(0, 1, 8'd240, 8'd200, 1); idle1(8'd0);
    drv1(0, 1, 8'd250, 8'd200, 1); idle1(8'd0);
    drv1(0, 1, 8'd255, 8'd200, 1); idle1(8'd0);
    @(negedge clk);
    chk("pulse_one_cycle", ov1, 0);
`ifdef EFF_1_CLIP_COUNT_EN
    chk("clip_count_5", cnt1, 5);
`endif

    // Hold: no strobe means the new input is ignored.
    drv1(0, 1, 8'd180, 8'd180, 0);
    idle1(8'd250);
    @(negedge clk);
    chk("hold_byte", cb1, 180);
    chk("hold_valid", ov1, 0);
    chk("hold_clipped", oc1, 0);

    // Reset mid-stream overrides a concurrent strobe.
    drv1(0, 1, 8'd250, 8'd200, 1);
    drv1(1, 1, 8'd250, 8'd0, 0);
    idle1(8'd123);
    chk("rst_byte", cb1, 0);
    chk("rst_clipped", oc1, 0);
    chk("rst_valid", ov1, 0);
`ifdef EFF_1_CLIP_COUNT_EN
    chk("rst_count", cnt1, 0);
`endif
    idle1(8'd123);
    chk("post_rst_byte", cb1, 0);

    // Back-to-back strobes.
    drv1(0, 1, 8'd190, 8'd190, 0);
    drv1(0, 1, 8'd195, 8'd195, 0);
    drv1(0, 1, 8'd200, 8'd200, 0);
    drv1(0, 1, 8'd205, 8'd200, 1);
    drv1(0, 1, 8'd210, 8'd200, 1);
    idle1(8'd0);
    @(negedge clk);
    chk("b2b_last_byte", cb1, 200);

    // Instance with a non-zero floor.
    drv2(1, 8'd49,  8'd50,  1);
    drv2(1, 8'd50,  8'd50,  0);
    drv2(1, 8'd128, 8'd128, 0);
    drv2(0, 8'd0,   8'd0,   0);
    repeat (3) @(negedge clk);
    chk("dut2_hold", cb2, 128);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
